mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle controller FSM for the MIPS datapath. It sequences a shared ALU, a single unified instruction/data memory port, the register file and the PC over IF/ID/EX/MEM/WB states. It supports a variable-latency memory through a ready handshake and traps illegal opcodes or memory timeouts. It uses the same ALUOp, GPRSel, WDSel and LOADSel encodings as the single-cycle ctrl block, so the existing alu, RF and load-extend units are reused unchanged.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ready in IF/MEM before trapping; 0 disables the timeout; counter width 8 bits.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, combinational
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  PC load enable
IRWrite  out  1  IR load enable
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs
ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = imm
EXTOp  out  1  1 = sign-extend immediate
ALUOp  out  5  ALU_NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, SLL 7, NOR 8, LUI 9, SRL 10
NPCOp  out  4  000 = PC+4, 001 = branch, 010 = jump, 011 = jr, 100 = jalr
GPRSel  out  2  00 = rd, 01 = rt, 10 = $31
WDSel  out  2  00 = ALU, 01 = MEM, 10 = PC
LOADSel  out  4  0 = lw, 1 = lb, 2 = lbu, 3 = lh
instr_done  out  1  one-cycle pulse when an instruction retires
trap  out  1  sticky; set on entry to TRAP
state  out  3  current state, for debug

Behaviour:
- States: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, TRAP = 7. The state register and wait counter reset asynchronously to IF and 0.
- While rst = 1, every output is 0 except state, which reads 0.
- IF: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = ADD. IRWrite = PCWrite = mem_ready (Mealy), NPCOp = 000. Go to ID on mem_ready; otherwise stay.
- ID: register Op/Funct into an internal class register: RALU, IALU, LOAD, STORE, BR, J, JR, JAL, JALR, ILL. Class ILL goes to TRAP; every other class goes to EX. After ID, Op/Funct are ignored until the next IF.
- EX:
  - RALU: ALUSrcA = 1, ALUSrcB = 00; go to WB.
  - IALU/LOAD/STORE: ALUSrcA = 1, ALUSrcB = 10; EXTOp = 1 except ori/lui; go to WB (IALU) or MEM.
  - BR: ALUOp = SUB, ALUSrcB = 00. PCWrite = (beq & Zero) | (bne & ~Zero), NPCOp = 001. Retire and go to IF.
  - J/JAL/JR/JALR: PCWrite = 1 with the matching NPCOp. JAL/JALR additionally set RegWrite = 1, WDSel = 10, GPRSel = 10 (JAL) or 00 (JALR). The PC is already PC+4 at this point. Retire and go to IF.
- MEM: IorD = 1. LOAD drives MemRead = 1 and goes to WB on mem_ready. STORE drives MemWrite = 1, retires and goes to IF on mem_ready. Both stay in MEM until mem_ready.
- WB: RegWrite = 1; GPRSel = 00 for RALU, 01 otherwise; WDSel = 01 for LOAD, 00 otherwise. Retire and go to IF.
- LOADSel is valid from EX through WB for the latched load type.
- instr_done is asserted in the final cycle of each instruction.
- Wait counter:
  - Clears on every state change.
  - Increments on each IF/MEM cycle with mem_ready = 0, saturating at 255.
  - If TIMEOUT != 0 and the count reaches TIMEOUT, go to TRAP next cycle; MemRead/MemWrite drop immediately.
- mem_ready outside IF/MEM is ignored.
- TRAP: all strobes 0, trap = 1; only rst exits TRAP.
- Cycle counts with zero-wait memory (mem_ready high on the first request cycle): branch/jump 3, R/I-ALU 4, store 4, load 5.
- Unsupported funct codes under Op = 0 are class ILL.
- Reset asserted mid-instruction aborts at once, with no write strobe glitch.

Test Plan:
- rst pulsed high, then released with mem_ready = 1 → state = 0, MemRead = 1; first edge gives IRWrite = PCWrite = 1 and state = 1.
- add (Op 0, Funct 0x20) with zero-wait memory → states 0,1,2,4; RegWrite = 1 only in WB with GPRSel = 00, WDSel = 00, ALUOp = 1; instr_done pulses in WB.
- lw (0x23) with mem_ready held low 3 cycles in MEM → MEM held 4 cycles with IorD = 1 and MemRead = 1; WB then has WDSel = 01, GPRSel = 01; 8 cycles total.
- beq (0x04) with Zero = 1, then bne (0x05) with Zero = 1 → PCWrite = 1 and NPCOp = 001 in EX for beq only; each instruction takes 3 cycles.
- jal (0x03) → EX has PCWrite = 1, NPCOp = 010, RegWrite = 1, GPRSel = 10, WDSel = 10.
- Illegal Op 0x3F → TRAP after ID with trap = 1 and all strobes 0 until reset. Separately, with TIMEOUT = 4 and mem_ready stuck at 0 in IF → TRAP entered after 4 wait cycles.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller sequencing IF/ID/EX/MEM/WB over a
// shared ALU and one unified memory port with a ready handshake.
module mc_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [4:0] ALUOp,
  output logic [3:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [3:0] LOADSel,
  output logic       instr_done,
  output logic       trap,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LOAD, C_STORE, C_BR,
    C_J, C_JR, C_JAL, C_JALR, C_ILL
  } cls_t;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_LUI  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;

  localparam logic [7:0] W_TO  = 8'(TIMEOUT);
  localparam bit         TO_EN = (TIMEOUT != 0);

  state_t     r_state, w_nxt;
  cls_t       r_cls, w_cls;
  logic [4:0] r_aluop, w_aluop;
  logic       r_ext, w_ext;
  logic       r_bne, w_bne;
  logic [3:0] r_lsel, w_lsel;
  logic [7:0] r_cnt;
  logic       w_to, w_wait, w_alu_cls, w_hold;

  always_comb begin
    w_cls   = C_ILL;
    w_aluop = ALU_NOP;
    w_ext   = 1'b0;
    w_lsel  = 4'd0;
    w_bne   = 1'b0;
    case (Op)
      6'h00: begin
        w_cls = C_RALU;
        case (Funct)
          6'h20, 6'h21: w_aluop = ALU_ADD;
          6'h22, 6'h23: w_aluop = ALU_SUB;
          6'h24:        w_aluop = ALU_AND;
          6'h25:        w_aluop = ALU_OR;
          6'h27:        w_aluop = ALU_NOR;
          6'h2A:        w_aluop = ALU_SLT;
          6'h2B:        w_aluop = ALU_SLTU;
          6'h00:        w_aluop = ALU_SLL;
          6'h02:        w_aluop = ALU_SRL;
          6'h08:        w_cls   = C_JR;
          6'h09:        w_cls   = C_JALR;
          default:      w_cls   = C_ILL;
        endcase
      end
      6'h02: w_cls = C_J;
      6'h03: w_cls = C_JAL;
      6'h04: w_cls = C_BR;
      6'h05: begin
        w_cls = C_BR;
        w_bne = 1'b1;
      end
      6'h08, 6'h09: begin
        w_cls = C_IALU; w_aluop = ALU_ADD; w_ext = 1'b1;
      end
      6'h0A: begin
        w_cls = C_IALU; w_aluop = ALU_SLT; w_ext = 1'b1;
      end
      6'h0B: begin
        w_cls = C_IALU; w_aluop = ALU_SLTU; w_ext = 1'b1;
      end
      6'h0C: begin
        w_cls = C_IALU; w_aluop = ALU_AND; w_ext = 1'b1;
      end
      6'h0D: begin
        w_cls = C_IALU; w_aluop = ALU_OR;
      end
      6'h0F: begin
        w_cls = C_IALU; w_aluop = ALU_LUI;
      end
      6'h23, 6'h20, 6'h24, 6'h21: begin
        w_cls   = C_LOAD;
        w_aluop = ALU_ADD;
        w_ext   = 1'b1;
        w_lsel  = (Op == 6'h23) ? 4'd0 :
                  (Op == 6'h20) ? 4'd1 :
                  (Op == 6'h24) ? 4'd2 : 4'd3;
      end
      6'h2B: begin
        w_cls = C_STORE; w_aluop = ALU_ADD; w_ext = 1'b1;
      end
      default: w_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_nxt;
  end

  // Decoded class is held so Op/Funct may change after ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 8'd0;
      r_cls   <= C_ILL;
      r_aluop <= ALU_NOP;
      r_ext   <= 1'b0;
      r_bne   <= 1'b0;
      r_lsel  <= 4'd0;
    end else begin
      if (w_nxt != r_state)
        r_cnt <= 8'd0;
      else if (w_wait && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == S_ID) begin
        r_cls   <= w_cls;
        r_aluop <= w_aluop;
        r_ext   <= w_ext;
        r_bne   <= w_bne;
        r_lsel  <= w_lsel;
      end
    end
  end

  assign w_wait = (r_state == S_IF || r_state == S_MEM) && !mem_ready;
  assign w_to   = TO_EN && (r_cnt == W_TO);
  assign w_alu_cls = (r_cls == C_RALU) || (r_cls == C_IALU) ||
                     (r_cls == C_LOAD) || (r_cls == C_STORE);
  assign w_hold = !rst && (r_state == S_EX || r_state == S_WB ||
                           (r_state == S_MEM && !w_to));
  assign state  = r_state;

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    NPCOp      = 4'd0;
    GPRSel     = 2'b00;
    WDSel      = 2'b00;
    LOADSel    = 4'd0;
    instr_done = 1'b0;
    trap       = 1'b0;
    w_nxt      = r_state;
    if (w_hold && w_alu_cls) begin
      ALUSrcA = 1'b1;
      ALUSrcB = (r_cls == C_RALU) ? 2'b00 : 2'b10;
      EXTOp   = r_ext;
      ALUOp   = r_aluop;
      LOADSel = r_lsel;
    end
    if (!rst) begin
      unique case (r_state)
        S_IF: begin
          if (w_to) begin
            w_nxt = S_TRAP;
          end else begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            ALUOp   = ALU_ADD;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) w_nxt = S_ID;
          end
        end
        S_ID: w_nxt = (w_cls == C_ILL) ? S_TRAP : S_EX;
        S_EX: begin
          unique case (r_cls)
            C_RALU, C_IALU: w_nxt = S_WB;
            C_LOAD, C_STORE: w_nxt = S_MEM;
            C_BR: begin
              ALUSrcA    = 1'b1;
              ALUOp      = ALU_SUB;
              NPCOp      = 4'd1;
              PCWrite    = r_bne ? !Zero : Zero;
              instr_done = 1'b1;
              w_nxt      = S_IF;
            end
            C_J, C_JAL: begin
              PCWrite    = 1'b1;
              NPCOp      = 4'd2;
              RegWrite   = (r_cls == C_JAL);
              WDSel      = (r_cls == C_JAL) ? 2'b10 : 2'b00;
              GPRSel     = (r_cls == C_JAL) ? 2'b10 : 2'b00;
              instr_done = 1'b1;
              w_nxt      = S_IF;
            end
            C_JR, C_JALR: begin
              PCWrite    = 1'b1;
              NPCOp      = (r_cls == C_JR) ? 4'd3 : 4'd4;
              RegWrite   = (r_cls == C_JALR);
              WDSel      = (r_cls == C_JALR) ? 2'b10 : 2'b00;
              instr_done = 1'b1;
              w_nxt      = S_IF;
            end
            default: w_nxt = S_TRAP;
          endcase
        end
        S_MEM: begin
          if (w_to) begin
            w_nxt = S_TRAP;
          end else begin
            IorD = 1'b1;
            if (r_cls == C_LOAD) begin
              MemRead = 1'b1;
              if (mem_ready) w_nxt = S_WB;
            end else begin
              MemWrite = 1'b1;
              if (mem_ready) begin
                instr_done = 1'b1;
                w_nxt      = S_IF;
              end
            end
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          GPRSel     = (r_cls == C_RALU) ? 2'b00 : 2'b01;
          WDSel      = (r_cls == C_LOAD) ? 2'b01 : 2'b00;
          instr_done = 1'b1;
          w_nxt      = S_IF;
        end
        S_TRAP: trap = 1'b1;
        default: w_nxt = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: transaction-level model of mc_ctrl; every cycle's expected
// output vector comes from the instruction's phase schedule.
module tb_mc_ctrl;
  localparam int TO = 4;

  typedef struct packed {
    logic       pcw, irw, iord, mr, mw, rw, asa;
    logic [1:0] asb;
    logic       ext;
    logic [4:0] alu;
    logic [3:0] npc;
    logic [1:0] gsel, wds;
    logic [3:0] lsel;
    logic       done, trap;
    logic [2:0] st;
  } out_t;

  typedef struct packed {
    logic [3:0] cls;
    logic [4:0] alu;
    logic       ext;
    logic [3:0] lsel;
    logic       bne;
  } info_t;

  localparam logic [3:0] RALU = 0, IALU = 1, LOAD = 2, STORE = 3, BR = 4;
  localparam logic [3:0] J = 5, JR = 6, JAL = 7, JALR = 8, ILL = 9;

  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA;
  logic EXTOp, instr_done, trap;
  logic [1:0] ALUSrcB, GPRSel, WDSel;
  logic [4:0] ALUOp;
  logic [3:0] NPCOp, LOADSel;
  logic [2:0] state;

  mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel),
    .WDSel(WDSel), .LOADSel(LOADSel), .instr_done(instr_done),
    .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  out_t  o, exp, last, ex_seen;
  bit    exp_v = 1'b0;
  string tag = "";
  int    n_cmp = 0, n_fail = 0;
  int    ncyc, done_at;

  assign o = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite,
              ALUSrcA, ALUSrcB, EXTOp, ALUOp, NPCOp, GPRSel, WDSel,
              LOADSel, instr_done, trap, state};

  always @(negedge clk) begin
    if (exp_v) begin
      n_cmp++;
      if (o !== exp) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h want %h", tag, $time, o, exp);
      end
    end
  end

  function automatic info_t dec(input logic [5:0] op, fn);
    info_t d;
    d = '0;
    d.cls = ILL;
    case (op)
      6'h00: begin
        d.cls = RALU;
        case (fn)
          6'h20, 6'h21: d.alu = 1;
          6'h22, 6'h23: d.alu = 2;
          6'h24: d.alu = 3;
          6'h25: d.alu = 4;
          6'h27: d.alu = 8;
          6'h2A: d.alu = 5;
          6'h2B: d.alu = 6;
          6'h00: d.alu = 7;
          6'h02: d.alu = 10;
          6'h08: d.cls = JR;
          6'h09: d.cls = JALR;
          default: d.cls = ILL;
        endcase
      end
      6'h02: d.cls = J;
      6'h03: d.cls = JAL;
      6'h04: d.cls = BR;
      6'h05: begin d.cls = BR; d.bne = 1; end
      6'h08, 6'h09: begin d.cls = IALU; d.alu = 1; d.ext = 1; end
      6'h0A: begin d.cls = IALU; d.alu = 5; d.ext = 1; end
      6'h0B: begin d.cls = IALU; d.alu = 6; d.ext = 1; end
      6'h0C: begin d.cls = IALU; d.alu = 3; d.ext = 1; end
      6'h0D: begin d.cls = IALU; d.alu = 4; end
      6'h0F: begin d.cls = IALU; d.alu = 9; end
      6'h23: begin d.cls = LOAD; d.alu = 1; d.ext = 1; d.lsel = 0; end
      6'h20: begin d.cls = LOAD; d.alu = 1; d.ext = 1; d.lsel = 1; end
      6'h24: begin d.cls = LOAD; d.alu = 1; d.ext = 1; d.lsel = 2; end
      6'h21: begin d.cls = LOAD; d.alu = 1; d.ext = 1; d.lsel = 3; end
      6'h2B: begin d.cls = STORE; d.alu = 1; d.ext = 1; end
      default: d.cls = ILL;
    endcase
    return d;
  endfunction

  function automatic out_t z0(input logic [2:0] st);
    out_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic out_t alu_ctl(input out_t b, input info_t d);
    out_t e;
    e = b;
    if (d.cls <= STORE) begin
      e.asa  = 1;
      e.asb  = (d.cls == RALU) ? 2'b00 : 2'b10;
      e.ext  = d.ext;
      e.alu  = d.alu;
      e.lsel = d.lsel;
    end
    return e;
  endfunction

  function automatic out_t f_if(input logic rdy);
    out_t e;
    e = z0(0);
    e.mr = 1; e.asb = 2'b01; e.alu = 1;
    e.pcw = rdy; e.irw = rdy;
    return e;
  endfunction

  function automatic out_t f_ex(input info_t d, input logic z);
    out_t e;
    e = alu_ctl(z0(2), d);
    case (d.cls)
      BR: begin
        e.asa = 1; e.alu = 2; e.npc = 1; e.done = 1;
        e.pcw = d.bne ? !z : z;
      end
      J:    begin e.pcw = 1; e.npc = 2; e.done = 1; end
      JAL:  begin
        e.pcw = 1; e.npc = 2; e.done = 1;
        e.rw = 1; e.wds = 2; e.gsel = 2;
      end
      JR:   begin e.pcw = 1; e.npc = 3; e.done = 1; end
      JALR: begin
        e.pcw = 1; e.npc = 4; e.done = 1;
        e.rw = 1; e.wds = 2;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t f_mem(input info_t d, input logic rdy);
    out_t e;
    e = alu_ctl(z0(3), d);
    e.iord = 1;
    if (d.cls == LOAD) e.mr = 1;
    else begin e.mw = 1; e.done = rdy; end
    return e;
  endfunction

  function automatic out_t f_wb(input info_t d);
    out_t e;
    e = alu_ctl(z0(4), d);
    e.rw = 1; e.done = 1;
    e.gsel = (d.cls == RALU) ? 2'b00 : 2'b01;
    e.wds  = (d.cls == LOAD) ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  task automatic step(input out_t e, input logic r, mr, z,
                      input logic [5:0] op, fn, input string t);
    rst = r; mem_ready = mr; Zero = z; Op = op; Funct = fn;
    exp = e; tag = t; exp_v = 1'b1;
    @(negedge clk);
    last = o;
    ncyc++;
    if (o.done && done_at == 0) done_at = ncyc;
    if (t == "ex") ex_seen = o;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string t, input int got, want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", t, got, want);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(z0(0), 1, 1, r1(), r6(), r6(), "rst");
  endtask

  task automatic trap_cycles(input int n);
    out_t e;
    e = z0(7);
    e.trap = 1;
    for (int i = 0; i < n; i++) step(e, 0, r1(), r1(), r6(), r6(), "trap");
  endtask

  // zsel < 0 gives a random Zero in EX; stop > 0 abandons after that cycle.
  task automatic run_instr(input logic [5:0] op, fn, input int wf, wm,
                           input int zsel, stop, output bit trapped);
    info_t d;
    logic  z;
    d = dec(op, fn);
    ncyc = 0; done_at = 0; trapped = 0;
    for (int k = 0; ; k++) begin
      if (k == TO) begin
        step(z0(0), 0, r1(), r1(), r6(), r6(), "if_timeout");
        trapped = 1;
        return;
      end
      step(f_if(k == wf), 0, k == wf, r1(), r6(), r6(), "if");
      if (ncyc == stop) return;
      if (k == wf) break;
    end
    step(z0(1), 0, r1(), r1(), op, fn, "id");
    if (ncyc == stop) return;
    if (d.cls == ILL) begin trapped = 1; return; end
    z = (zsel < 0) ? r1() : zsel[0];
    step(f_ex(d, z), 0, r1(), z, r6(), r6(), "ex");
    if (ncyc == stop) return;
    if (d.cls >= BR) return;
    if (d.cls == LOAD || d.cls == STORE) begin
      for (int k = 0; ; k++) begin
        if (k == TO) begin
          step(z0(3), 0, r1(), r1(), r6(), r6(), "mem_timeout");
          trapped = 1;
          return;
        end
        step(f_mem(d, k == wm), 0, k == wm, r1(), r6(), r6(), "mem");
        if (ncyc == stop) return;
        if (k == wm) break;
      end
      if (d.cls == STORE) return;
    end
    step(f_wb(d), 0, r1(), r1(), r6(), r6(), "wb");
  endtask

  logic [5:0] OPS [20] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                           6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                           6'h0D, 6'h0F, 6'h23, 6'h20, 6'h24, 6'h21,
                           6'h2B, 6'h3F};
  logic [5:0] FNS [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h08,
                           6'h09, 6'h01, 6'h26, 6'h3F};

  initial begin
    bit tr;
    logic [5:0] op, fn;
    int wf, wm, stop;

    do_reset(2);

    run_instr(6'h00, 6'h20, 0, 0, -1, -1, tr);
    lit("add_cycles", done_at, 4);

    run_instr(6'h23, 6'h11, 0, 3, -1, -1, tr);
    lit("lw_wait3_cycles", done_at, 8);
    run_instr(6'h23, 6'h00, 0, 0, -1, -1, tr);
    lit("lw_cycles", done_at, 5);

    run_instr(6'h04, 6'h00, 0, 0, 1, -1, tr);
    lit("beq_cycles", done_at, 3);
    lit("beq_pcwrite", int'(ex_seen.pcw), 1);
    lit("beq_npcop", int'(ex_seen.npc), 1);
    run_instr(6'h05, 6'h00, 0, 0, 1, -1, tr);
    lit("bne_cycles", done_at, 3);
    lit("bne_pcwrite", int'(ex_seen.pcw), 0);

    run_instr(6'h03, 6'h15, 0, 0, -1, -1, tr);
    lit("jal_npcop", int'(ex_seen.npc), 2);
    lit("jal_gprsel", int'(ex_seen.gsel), 2);
    lit("jal_wdsel", int'(ex_seen.wds), 2);
    lit("jal_regwrite", int'(ex_seen.rw), 1);

    run_instr(6'h2B, 6'h00, 0, 0, -1, -1, tr);
    lit("sw_cycles", done_at, 4);

    run_instr(6'h3F, 6'h00, 0, 0, -1, -1, tr);
    trap_cycles(5);
    lit("ill_trap", int'(last.trap), 1);
    lit("ill_state", int'(last.st), 7);
    do_reset(1);

    run_instr(6'h00, 6'h20, 10, 0, -1, -1, tr);
    trap_cycles(2);
    lit("if_timeout_trap", int'(last.trap), 1);
    do_reset(1);

    run_instr(6'h2B, 6'h00, 0, 2, -1, 4, tr);
    do_reset(1);
    run_instr(6'h00, 6'h25, 1, 0, -1, -1, tr);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? r6() : OPS[$urandom_range(0, 19)];
      fn = ($urandom_range(0, 7) == 0) ? r6() : FNS[$urandom_range(0, 15)];
      wf = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 6)
                                        : $urandom_range(0, 3);
      wm = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 6)
                                        : $urandom_range(0, 3);
      stop = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 4) : -1;
      run_instr(op, fn, wf, wm, -1, stop, tr);
      if (tr) begin
        trap_cycles($urandom_range(1, 3));
        do_reset($urandom_range(1, 2));
      end else if (stop > 0 && ncyc == stop) begin
        do_reset(1);
      end
    end

    exp_v = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
